// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, WIDTH iterations per op.
// Optional MULDIV_DIVZERO_FAST_EN: adds div_zero and a one-edge divide-by-zero path.
module muldiv_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef MULDIV_DIVZERO_FAST_EN
    ,output logic            div_zero
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL_LO, OP_MUL_HI, OP_DIV, OP_MOD} op_t;

    state_t             state;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] work;
    logic [CW-1:0]      counter;

    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] work_nxt;
    logic [WIDTH-1:0]   res_nxt;

    assign accept = start && (state != S_RUN);

    // MUL keeps the running product high half in work[2W-1:W]; DIV keeps the
    // remainder there and shifts quotient bits into work[W-1:0].
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        div_shift = {work[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        // On a successful subtract the difference is below b_q, so W bits suffice.
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        work_nxt  = '0;
        if (op_q == OP_MUL_LO || op_q == OP_MUL_HI)
            work_nxt = {mul_sum, work[WIDTH-1:1]};
        else
            work_nxt = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), work[WIDTH-2:0], div_ge};
        res_nxt = '0;
        case (op_q)
            OP_MUL_LO, OP_DIV: res_nxt = work_nxt[WIDTH-1:0];
            OP_MUL_HI, OP_MOD: res_nxt = work_nxt[2*WIDTH-1:WIDTH];
            default:           res_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            op_q    <= OP_MUL_LO;
            a_q     <= '0;
            b_q     <= '0;
            work    <= '0;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
`ifdef MULDIV_DIVZERO_FAST_EN
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULDIV_DIVZERO_FAST_EN
            div_zero <= 1'b0;
`endif
            if (accept) begin
                op_q    <= op_t'(op);
                a_q     <= operand_a;
                b_q     <= operand_b;
                work    <= '0;
                counter <= '0;
                state   <= S_RUN;
                busy    <= 1'b1;
`ifdef MULDIV_DIVZERO_FAST_EN
                if (op[1] && operand_b == '0) begin
                    state    <= S_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    result   <= op[0] ? operand_a : '1;
                end
`endif
            end else begin
                case (state)
                    S_RUN: begin
                        work    <= work_nxt;
                        counter <= counter + CW'(1);
                        if (op_q == OP_MUL_LO || op_q == OP_MUL_HI)
                            b_q <= b_q >> 1;
                        else
                            a_q <= a_q << 1;
                        if (counter == CW'(WIDTH - 1)) begin
                            state  <= S_DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= res_nxt;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic reference model.
// Define MULDIV_DIVZERO_FAST_EN to exercise the fast divide-by-zero build.
module tb_muldiv_unit;

    logic       CLK;
    logic       RESET;
    logic       start;
    logic [1:0] op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       busy;
    logic       done;
    logic [7:0] result;
`ifdef MULDIV_DIVZERO_FAST_EN
    logic       div_zero;
`endif

    int vectors = 0;
    int errors  = 0;

    muldiv_unit #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
`ifdef MULDIV_DIVZERO_FAST_EN
        ,.div_zero (div_zero)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (o)
            2'd0:    return p[7:0];
            2'd1:    return p[15:8];
            2'd2:    return (b == 8'd0) ? 8'hFF : a / b;
            default: return (b == 8'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit fast_dz(input logic [1:0] o, input logic [7:0] b);
`ifdef MULDIV_DIVZERO_FAST_EN
        return o[1] && (b == 8'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the inputs to prove they were latched.
    task automatic launch(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
        op = 2'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
    endtask

    task automatic wait_done(output int edges, output int busy_cyc);
        edges = 0;
        busy_cyc = 0;
        while (edges < 40) begin
            @(negedge CLK);
            edges++;
            if (busy) busy_cyc++;
            if (done) break;
        end
    endtask

    task automatic run_check(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input string tag);
        int e, bc;
        bit fz;
        fz = fast_dz(o, b);
        launch(o, a, b);
        wait_done(e, bc);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(e), fz ? 32'd1 : 32'd9);
        chk({tag, "_busy_cycles"}, 32'(bc), fz ? 32'd0 : 32'd8);
        chk({tag, "_result"}, 32'(result), 32'(model(o, a, b)));
`ifdef MULDIV_DIVZERO_FAST_EN
        chk({tag, "_div_zero"}, 32'(div_zero), 32'(fz));
`endif
        @(negedge CLK);
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_result_hold"}, 32'(result), 32'(model(o, a, b)));
`ifdef MULDIV_DIVZERO_FAST_EN
        chk({tag, "_div_zero_drop"}, 32'(div_zero), 32'd0);
`endif
    endtask

    initial begin
        int e, bc, pulses;
        logic [1:0] ro;
        logic [7:0] ra, rb;

        RESET = 1'b1; start = 1'b0; op = 2'd0; operand_a = 8'd0; operand_b = 8'd0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
`ifdef MULDIV_DIVZERO_FAST_EN
        chk("reset_div_zero", 32'(div_zero), 32'd0);
`endif
        RESET = 1'b0;

        run_check(2'd0, 8'd13,  8'd11, "t1_mul_lo");
        run_check(2'd1, 8'd200, 8'd200, "t2_mul_hi");
        run_check(2'd0, 8'd200, 8'd200, "t2_mul_lo");
        run_check(2'd2, 8'd200, 8'd7,   "t3_div");
        run_check(2'd3, 8'd200, 8'd7,   "t3_mod");
        run_check(2'd2, 8'h55,  8'd0,   "t4_div0");
        run_check(2'd3, 8'h55,  8'd0,   "t4_mod0");
        run_check(2'd0, 8'hFF,  8'hFF,  "edge_mul_lo_max");
        run_check(2'd1, 8'hFF,  8'hFF,  "edge_mul_hi_max");
        run_check(2'd2, 8'hFF,  8'd1,   "edge_div_by1");
        run_check(2'd3, 8'd6,   8'd7,   "edge_mod_small");

        // Start pulse mid-RUN is ignored; start held through DONE chains a second op.
        launch(2'd0, 8'd13, 8'd11);
        repeat (2) @(negedge CLK);
        start = 1'b1; op = 2'd0; operand_a = 8'd1; operand_b = 8'd1;
        @(negedge CLK);
        start = 1'b1; op = 2'd2; operand_a = 8'd200; operand_b = 8'd7;
        wait_done(e, bc);
        chk("t5_first_done", 32'(done), 32'd1);
        chk("t5_first_latency", 32'(e), 32'd6);
        chk("t5_first_result", 32'(result), 32'h8F);
        @(negedge CLK);
        start = 1'b0;
        chk("t5_b2b_done_drop", 32'(done), 32'd0);
        chk("t5_b2b_busy", 32'(busy), 32'd1);
        wait_done(e, bc);
        chk("t5_second_done", 32'(done), 32'd1);
        chk("t5_second_latency", 32'(e), 32'd8);
        chk("t5_second_result", 32'(result), 32'(model(2'd2, 8'd200, 8'd7)));
        @(negedge CLK);

        // Reset mid-RUN aborts without a done pulse.
        launch(2'd2, 8'd200, 8'd7);
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_result", 32'(result), 32'd0);
        RESET = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge CLK);
            if (done || busy) pulses++;
        end
        chk("t6_no_activity", 32'(pulses), 32'd0);
        run_check(2'd3, 8'd200, 8'd7, "t6_after");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            run_check(ro, ra, rb, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
